// File: rtl/instruction_fetch_if.sv
// Fetch-side bundle: program memory read port, instruction hand-off to execute,
// and the branch redirect coming back from execute.
interface instruction_fetch_if;
  localparam int unsigned AW = 8;
  localparam int unsigned DW = 8;

  logic [AW-1:0] address_bus;
  logic [DW-1:0] data_bus;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr_byte0;
  logic [DW-1:0] instr_byte1;
  logic          instr_len2;
  logic [AW-1:0] instr_pc;
  logic          instr_illegal;
  logic          branch_valid;
  logic [AW-1:0] branch_target;

  modport master (
    output address_bus,
    input  data_bus,
    output instr_valid,
    input  instr_ready,
    output instr_byte0,
    output instr_byte1,
    output instr_len2,
    output instr_pc,
    output instr_illegal,
    input  branch_valid,
    input  branch_target
  );

  modport slave (
    input  address_bus,
    output data_bus,
    input  instr_valid,
    output instr_ready,
    input  instr_byte0,
    input  instr_byte1,
    input  instr_len2,
    input  instr_pc,
    input  instr_illegal,
    output branch_valid,
    output branch_target
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: reads 1- or 2-byte instructions from an 8-bit program memory,
// presents them to execute with a valid/ready hold, and honours branch redirects.
module instruction_fetch #(
  parameter logic [7:0] RESET_PC        = 8'd0,
  parameter bit         HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  instruction_fetch_if.master bus
);
  localparam int unsigned W = 8;

  typedef enum logic [1:0] {FETCH0, FETCH1, HOLD, STOP} state_t;

  state_t       state;
  logic [W-1:0] pc;
  logic [W-1:0] byte0;
  logic [W-1:0] byte1;
  logic [W-1:0] ipc;
  logic         valid;
  logic         len2;
  logic         illegal;
  logic         legal_c;
  logic         two_byte_c;

  // Opcode decode of the byte currently on the memory bus.
  always_comb begin
    legal_c = 1'b0;
    casez (bus.data_bus)
      8'b0000_????, 8'b0010_????, 8'b0100_????,
      8'b0101_????, 8'b0110_????, 8'b1100_????: legal_c = 1'b1;
      8'b1000_00??, 8'b1000_11??, 8'b1001_00??,
      8'b1001_01??, 8'b1001_10??, 8'b1001_11??: legal_c = 1'b1;
      8'hA8, 8'hB0, 8'hB4, 8'h70:               legal_c = 1'b1;
      default:                                  legal_c = 1'b0;
    endcase
  end

  // Undefined opcodes are always treated as 1-byte.
  assign two_byte_c = legal_c &&
                      ((bus.data_bus[7:2] == 6'b100000) ||
                       (bus.data_bus[7:2] == 6'b100011) ||
                       (bus.data_bus[7:5] == 3'b101));

  // Fetch sequencer; a redirect beats every transition except reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= FETCH0;
      pc      <= RESET_PC;
      valid   <= 1'b0;
      byte0   <= '0;
      byte1   <= '0;
      ipc     <= '0;
      len2    <= 1'b0;
      illegal <= 1'b0;
    end else if (bus.branch_valid) begin
      state <= FETCH0;
      pc    <= bus.branch_target;
      valid <= 1'b0;
    end else begin
      case (state)
        FETCH0: begin
          byte0   <= bus.data_bus;
          ipc     <= pc;
          pc      <= pc + W'(1);
          illegal <= ~legal_c;
          len2    <= two_byte_c;
          if (two_byte_c) begin
            state <= FETCH1;
          end else begin
            byte1 <= '0;
            valid <= 1'b1;
            state <= HOLD;
          end
        end
        FETCH1: begin
          byte1 <= bus.data_bus;
          pc    <= pc + W'(1);
          valid <= 1'b1;
          state <= HOLD;
        end
        HOLD: begin
          if (bus.instr_ready) begin
            valid <= 1'b0;
            state <= (illegal && HALT_ON_ILLEGAL) ? STOP : FETCH0;
          end
        end
        STOP: begin
        end
        default: state <= FETCH0;
      endcase
    end
  end

  assign bus.address_bus   = pc;
  assign bus.instr_valid   = valid;
  assign bus.instr_byte0   = byte0;
  assign bus.instr_byte1   = byte1;
  assign bus.instr_len2    = len2;
  assign bus.instr_pc      = ipc;
  assign bus.instr_illegal = illegal;
endmodule
